ac97_codec_resp: RTL and testbench
==================================

AC97_CODEC_RESP -- requirements
Module: ac97_codec_resp

Interface
REQ-001 READY_DELAY, default 16, sys_clk cycles from reset release to codec-ready assertion (range 1..65535).
REQ-002 VENDOR_ID1, default 16'h4D4C, read-only value of register 0x7C.
REQ-003 VENDOR_ID2, default 16'h4D53, read-only value of register 0x7E.
REQ-004 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-005 sys_rst  in  1  reset, synchronous, active-high.
REQ-006 down_next_frame  in  1  one-cycle strobe: a downstream frame's slots are valid this cycle.
REQ-007 down_addr_valid  in  1  slot-1 (command address) tag bit.
REQ-008 down_addr  in  20  slot 1: bit19 = 1 read / 0 write, bits 18:12 register index, 11:0 ignored.
REQ-009 down_data_valid  in  1  slot-2 (command data) tag bit.
REQ-010 down_data  in  20  slot 2: bits 19:4 write data, 3:0 ignored.
REQ-011 up_next_frame  in  1  one-cycle strobe: upstream frame slots are sampled this cycle; outputs below must be stable in the same cycle.
REQ-012 up_frame_valid  out  1  codec-ready tag bit.
REQ-013 up_addr_valid  out  1  slot-1 (status address) tag bit.
REQ-014 up_addr  out  20  {1'b0, index[6:0], 12'd0}.
REQ-015 up_data_valid  out  1  slot-2 (status data) tag bit.
REQ-016 up_data  out  20  {reg_value[15:0], 4'd0}.
REQ-017 master_vol  out  16  current value of register 0x02.
REQ-018 pcm_vol  out  16  current value of register 0x18.

Function
REQ-019 Register file: 64 x 16-bit words addressing even indices 0x00..0x7E; odd index writes ignored, odd index reads return 16'h0000.
REQ-020 Defaults: 0x02 = 16'h8000, 0x18 = 16'h8808, 0x26 = 16'h000F, 0x7C = VENDOR_ID1, 0x7E = VENDOR_ID2, all others 16'h0000.
REQ-021 Command decode only on down_next_frame with down_addr_valid = 1; otherwise the frame is ignored.
REQ-022 Write: bit19 = 0 and down_data_valid = 1; register updated at the clock edge ending the strobe cycle; write with down_data_valid = 0 is dropped.
REQ-023 Write to 0x00 (any data) restores all registers to REQ-020 defaults on that edge; register 0x00 itself stays 16'h0000.
REQ-024 Writes to 0x26 update only bits 15:4; bits 3:0 always read 4'hF; writes to 0x7C/0x7E are dropped.
REQ-025 Read: bit19 = 1; latches pending = 1, pend_index = index; down_data_valid is ignored.
REQ-026 A new read arriving while pending = 1 overwrites pend_index (newest wins, one reply only).
REQ-027 On up_next_frame with pending = 1: up_addr_valid = up_data_valid = 1, up_addr/up_data from pend_index, up_data = current register value (includes any write completed before this cycle); pending clears at that edge.
REQ-028 With pending = 0: up_addr_valid = up_data_valid = 0, up_addr = up_data = 0.
REQ-029 down_next_frame and up_next_frame in the same cycle: the reply uses the pre-existing pending state; a read in the same cycle becomes pending for the next up frame; a write in the same cycle is not visible in that reply.
REQ-030 Latency: read decoded in cycle N is returned at the first up_next_frame strictly after N.
REQ-031 Ready counter: 16-bit down-counter loaded with READY_DELAY at reset; up_frame_valid = 1 once it reaches 0 and stays 1 until reset.
REQ-032 While up_frame_valid = 0, commands are ignored and no reply is produced.

Reset
REQ-033 sys_rst: registers to REQ-020 defaults, pending = 0, pend_index = 0, counter = READY_DELAY, up_frame_valid = 0, all up_* = 0, master_vol = 16'h8000, pcm_vol = 16'h8808.
REQ-034 Reset mid-operation discards any pending read; no reply is emitted for it.

Structure
REQ-035 Shared package holds register index constants (0x00, 0x02, 0x18, 0x26, 0x7C, 0x7E), slot bit positions and default values.
REQ-036 Single module; register file is an inline array, no sub-module.

Verification
REQ-037 Reset, READY_DELAY = 16; pulse up_next_frame each 4 cycles -> up_frame_valid = 0 for 16 cycles, then 1; no command is accepted before that.
REQ-038 Write 0x18 = 16'h1F1F, then read 0x18 -> next up frame: up_addr = 20'h18000, up_data = 20'h1F1F0, pcm_vol = 16'h1F1F.
REQ-039 Read 0x7C then read 0x26 before any up frame -> single reply: index 0x26, data 16'h000F; following up frame has addr/data valid = 0.
REQ-040 Write 0x02 = 16'h0000, write 0x00, read 0x02 -> reply 16'h8000; master_vol = 16'h8000.
REQ-041 Same-cycle down/up strobes with pending read 0x7E plus new read 0x02 -> reply 0x7E = 16'h4D53 now, 0x02 at the next up frame.
REQ-042 Read 0x18 pending, assert sys_rst for 1 cycle -> no reply after ready; pcm_vol = 16'h8808.

Source files
------------

// File: rtl/ac97_codec_resp_pkg.sv
// AC'97 codec responder shared definitions.
// Register indices, slot field positions and register default values.
// Defaults are resolved per register-file word by reg_default().
package ac97_codec_resp_pkg;

   localparam int NUM_WORDS = 64;

   // Register indices (7-bit AC'97 register address space)
   localparam logic [6:0] IDX_RESET  = 7'h00;
   localparam logic [6:0] IDX_MASTER = 7'h02;
   localparam logic [6:0] IDX_PCM    = 7'h18;
   localparam logic [6:0] IDX_POWER  = 7'h26;
   localparam logic [6:0] IDX_VID1   = 7'h7C;
   localparam logic [6:0] IDX_VID2   = 7'h7E;

   // Word positions in the 64-entry file (index / 2)
   localparam logic [5:0] W_MASTER = IDX_MASTER[6:1];
   localparam logic [5:0] W_PCM    = IDX_PCM[6:1];
   localparam logic [5:0] W_POWER  = IDX_POWER[6:1];
   localparam logic [5:0] W_VID1   = IDX_VID1[6:1];
   localparam logic [5:0] W_VID2   = IDX_VID2[6:1];

   // Slot field positions
   localparam int SLOT_RW_BIT = 19;
   localparam int SLOT_IDX_HI = 18;
   localparam int SLOT_IDX_LO = 12;
   localparam int SLOT_DAT_HI = 19;
   localparam int SLOT_DAT_LO = 4;

   // Default register values
   localparam logic [15:0] DEF_MASTER = 16'h8000;
   localparam logic [15:0] DEF_PCM    = 16'h8808;
   localparam logic [15:0] DEF_POWER  = 16'h000F;

   // Default value of one register-file word; vendor IDs come from the instance
   function automatic logic [15:0] reg_default(input logic [5:0]  word,
                                               input logic [15:0] vid1,
                                               input logic [15:0] vid2);
      logic [15:0] v;
      v = 16'h0000;
      case (word)
         W_MASTER: v = DEF_MASTER;
         W_PCM:    v = DEF_PCM;
         W_POWER:  v = DEF_POWER;
         W_VID1:   v = vid1;
         W_VID2:   v = vid2;
         default:  v = 16'h0000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/ac97_codec_resp.sv
// AC'97 codec register responder: decodes slot-1/2 commands, returns one status reply.
// Latency: a read decoded in cycle N is answered on the first up frame strictly after N.
// Backpressure: none; newest pending read wins, commands ignored until codec-ready.
module ac97_codec_resp
   import ac97_codec_resp_pkg::*;
#(
   parameter int unsigned READY_DELAY = 16,
   parameter logic [15:0] VENDOR_ID1  = 16'h4D4C,
   parameter logic [15:0] VENDOR_ID2  = 16'h4D53
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        down_next_frame,
   input  logic        down_addr_valid,
   input  logic [19:0] down_addr,
   input  logic        down_data_valid,
   input  logic [19:0] down_data,
   input  logic        up_next_frame,
   output logic        up_frame_valid,
   output logic        up_addr_valid,
   output logic [19:0] up_addr,
   output logic        up_data_valid,
   output logic [19:0] up_data,
   output logic [15:0] master_vol,
   output logic [15:0] pcm_vol
);

   logic [15:0] r_regs [0:NUM_WORDS-1];
   logic [15:0] r_cnt;
   logic        r_pending;
   logic [6:0]  r_pend_index;

   logic        w_ready;
   logic        w_cmd;
   logic [6:0]  w_idx;
   logic [15:0] w_wdata;
   logic        w_is_read;
   logic        w_is_write;
   logic        w_soft_reset;
   logic        w_wr_en;
   logic        w_reply;
   logic [15:0] w_rd_val;
   logic        w_unused;

   // Ignored slot bits are folded here so they are visibly consumed
   assign w_unused = ^{down_addr[SLOT_IDX_LO-1:0], down_data[SLOT_DAT_LO-1:0]};

   assign w_ready      = (r_cnt == 16'd0);
   assign w_cmd        = down_next_frame & down_addr_valid & w_ready;
   assign w_idx        = down_addr[SLOT_IDX_HI:SLOT_IDX_LO];
   assign w_wdata      = down_data[SLOT_DAT_HI:SLOT_DAT_LO];
   assign w_is_read    = w_cmd &  down_addr[SLOT_RW_BIT];
   assign w_is_write   = w_cmd & ~down_addr[SLOT_RW_BIT] & down_data_valid;
   assign w_soft_reset = w_is_write & (w_idx == IDX_RESET);
   assign w_wr_en      = w_is_write & ~w_idx[0];
   assign w_reply      = up_next_frame & r_pending;

   // Odd indices have no storage and read as zero
   assign w_rd_val = r_pend_index[0] ? 16'h0000 : r_regs[r_pend_index[6:1]];

   // Codec-ready countdown: loaded at reset, sticks at zero
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_cnt <= 16'(READY_DELAY);
      end else if (r_cnt != 16'd0) begin
         r_cnt <= r_cnt - 16'd1;
      end
   end

   // Pending read: a new read overrides the clear from a same-cycle reply
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_pending    <= 1'b0;
         r_pend_index <= 7'd0;
      end else if (w_is_read) begin
         r_pending    <= 1'b1;
         r_pend_index <= w_idx;
      end else if (w_reply) begin
         r_pending    <= 1'b0;
      end
   end

   // Register file: defaults on reset or reset-register write, else command writes
   always_ff @(posedge sys_clk) begin
      if (sys_rst || w_soft_reset) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            r_regs[i] <= reg_default(6'(i), VENDOR_ID1, VENDOR_ID2);
         end
      end else if (w_wr_en) begin
         case (w_idx)
            IDX_POWER: r_regs[W_POWER] <= {w_wdata[15:4], 4'hF};
            IDX_VID1, IDX_VID2: begin
               // vendor IDs are read-only
            end
            default:   r_regs[w_idx[6:1]] <= w_wdata;
         endcase
      end
   end

   assign up_frame_valid = w_ready;
   assign up_addr_valid  = r_pending;
   assign up_data_valid  = r_pending;
   assign up_addr        = r_pending ? {1'b0, r_pend_index, 12'd0} : 20'd0;
   assign up_data        = r_pending ? {w_rd_val, 4'd0} : 20'd0;
   assign master_vol     = r_regs[W_MASTER];
   assign pcm_vol        = r_regs[W_PCM];

endmodule

// File: tb/tb_ac97_codec_resp.sv
// Bench for ac97_codec_resp: directed command sequences with a register-map model.
// Model is keyed by full 7-bit index; outputs compared on every falling edge.
// Literal expectations at key points pin both the model and the DUT.
module tb_ac97_codec_resp;

   localparam int unsigned READY_DELAY = 16;
   localparam logic [15:0] VID1 = 16'h4D4C;
   localparam logic [15:0] VID2 = 16'h4D53;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        down_next_frame = 1'b0;
   logic        down_addr_valid = 1'b0;
   logic [19:0] down_addr = '0;
   logic        down_data_valid = 1'b0;
   logic [19:0] down_data = '0;
   logic        up_next_frame = 1'b0;
   logic        up_frame_valid;
   logic        up_addr_valid;
   logic [19:0] up_addr;
   logic        up_data_valid;
   logic [19:0] up_data;
   logic [15:0] master_vol;
   logic [15:0] pcm_vol;

   int n_vec = 0;
   int n_err = 0;

   ac97_codec_resp #(
      .READY_DELAY(READY_DELAY),
      .VENDOR_ID1 (VID1),
      .VENDOR_ID2 (VID2)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .down_next_frame(down_next_frame),
      .down_addr_valid(down_addr_valid),
      .down_addr      (down_addr),
      .down_data_valid(down_data_valid),
      .down_data      (down_data),
      .up_next_frame  (up_next_frame),
      .up_frame_valid (up_frame_valid),
      .up_addr_valid  (up_addr_valid),
      .up_addr        (up_addr),
      .up_data_valid  (up_data_valid),
      .up_data        (up_data),
      .master_vol     (master_vol),
      .pcm_vol        (pcm_vol)
   );

   initial forever #5 sys_clk = ~sys_clk;

   // ---------------- behavioural model ----------------
   logic [15:0] m_reg [0:127];
   bit          m_pend = 1'b0;
   logic [6:0]  m_idx = '0;
   int unsigned m_cyc = 0;

   task automatic m_defaults();
      for (int i = 0; i < 128; i++) m_reg[i] = 16'h0000;
      m_reg[7'h02] = 16'h8000;
      m_reg[7'h18] = 16'h8808;
      m_reg[7'h26] = 16'h000F;
      m_reg[7'h7C] = VID1;
      m_reg[7'h7E] = VID2;
   endtask

   function automatic logic [15:0] m_read(input logic [6:0] idx);
      return idx[0] ? 16'h0000 : m_reg[idx];
   endfunction

   task automatic model_step();
      logic [6:0] idx;
      bit ready;
      if (sys_rst) begin
         m_defaults();
         m_pend = 1'b0;
         m_idx  = '0;
         m_cyc  = 0;
      end else begin
         ready = (m_cyc >= READY_DELAY);
         if (up_next_frame && m_pend) m_pend = 1'b0;
         if (ready && down_next_frame && down_addr_valid) begin
            idx = down_addr[18:12];
            if (down_addr[19]) begin
               m_pend = 1'b1;
               m_idx  = idx;
            end else if (down_data_valid) begin
               if (idx == 7'h00)                       m_defaults();
               else if (idx == 7'h26)                  m_reg[idx] = {down_data[19:8], 4'hF};
               else if (idx != 7'h7C && idx != 7'h7E)  m_reg[idx] = down_data[19:4];
            end
         end
         if (m_cyc < 100000) m_cyc++;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model advances on each rising edge, with the inputs the DUT also sees
   initial forever begin
      @(posedge sys_clk);
      model_step();
   end

   // Compare every falling edge; reply fields only where they are defined
   initial forever begin
      @(negedge sys_clk);
      check("m frame_valid", {31'd0, up_frame_valid}, {31'd0, m_cyc >= READY_DELAY});
      check("m master_vol", {16'd0, master_vol}, {16'd0, m_reg[7'h02]});
      check("m pcm_vol", {16'd0, pcm_vol}, {16'd0, m_reg[7'h18]});
      if (m_pend && up_next_frame) begin
         check("m addr_vld", {31'd0, up_addr_valid}, 32'd1);
         check("m data_vld", {31'd0, up_data_valid}, 32'd1);
         check("m up_addr", {12'd0, up_addr}, {12'd0, 1'b0, m_idx, 12'd0});
         check("m up_data", {12'd0, up_data}, {12'd0, m_read(m_idx), 4'd0});
      end else if (!m_pend) begin
         check("m addr_vld idle", {31'd0, up_addr_valid}, 32'd0);
         check("m data_vld idle", {31'd0, up_data_valid}, 32'd0);
         check("m up_addr idle", {12'd0, up_addr}, 32'd0);
         check("m up_data idle", {12'd0, up_data}, 32'd0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clr_cmd();
      down_next_frame = 1'b0;
      down_addr_valid = 1'b0;
      down_addr       = '0;
      down_data_valid = 1'b0;
      down_data       = '0;
   endtask

   task automatic set_cmd(input bit rd, input logic [6:0] idx, input logic [15:0] d, input bit dv);
      down_next_frame = 1'b1;
      down_addr_valid = 1'b1;
      down_addr       = {rd, idx, 12'hABC};
      down_data_valid = dv;
      down_data       = {d, 4'h5};
   endtask

   task automatic cmd(input bit rd, input logic [6:0] idx, input logic [15:0] d, input bit dv);
      set_cmd(rd, idx, d, dv);
      tick();
      clr_cmd();
   endtask

   // One up frame with literal expectations on the reply fields
   task automatic up_chk(input string name, input bit av, input logic [19:0] a, input logic [19:0] d);
      up_next_frame = 1'b1;
      @(negedge sys_clk);
      #1;
      check({name, " addr_vld"}, {31'd0, up_addr_valid}, {31'd0, av});
      check({name, " data_vld"}, {31'd0, up_data_valid}, {31'd0, av});
      check({name, " up_addr"}, {12'd0, up_addr}, {12'd0, a});
      check({name, " up_data"}, {12'd0, up_data}, {12'd0, d});
      tick();
      up_next_frame = 1'b0;
      clr_cmd();
   endtask

   task automatic idle_frames(input int n);
      for (int i = 0; i < n; i++) begin
         up_next_frame = (i % 4 == 0);
         tick();
      end
      up_next_frame = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      m_defaults();
      sys_rst = 1'b1;
      tick(); tick();
      @(negedge sys_clk); #1;
      check("rst frame_valid", {31'd0, up_frame_valid}, 32'd0);
      check("rst addr_vld", {31'd0, up_addr_valid}, 32'd0);
      check("rst master_vol", {16'd0, master_vol}, 32'h8000);
      check("rst pcm_vol", {16'd0, pcm_vol}, 32'h8808);
      tick();
      sys_rst = 1'b0;

      // Ready window: commands before the 16th edge are ignored
      for (int i = 0; i < 20; i++) begin
         clr_cmd();
         up_next_frame = (i % 4 == 0);
         if (i == 3)  set_cmd(1'b0, 7'h18, 16'h1234, 1'b1);
         if (i == 6)  set_cmd(1'b1, 7'h02, 16'h0000, 1'b0);
         if (i == 15) set_cmd(1'b0, 7'h18, 16'h5678, 1'b1);
         if (i == 17) set_cmd(1'b1, 7'h7C, 16'h0000, 1'b0);
         @(negedge sys_clk); #1;
         check("ready window", {31'd0, up_frame_valid}, {31'd0, i >= 16});
         tick();
      end
      clr_cmd();
      up_next_frame = 1'b0;
      check("early write dropped", {16'd0, pcm_vol}, 32'h8808);
      up_chk("vid1 read", 1'b1, 20'h7C000, 20'h4D4C0);

      // Write then read PCM volume
      cmd(1'b0, 7'h18, 16'h1F1F, 1'b1);
      cmd(1'b1, 7'h18, 16'h0000, 1'b0);
      up_chk("pcm read", 1'b1, 20'h18000, 20'h1F1F0);
      check("pcm_vol", {16'd0, pcm_vol}, 32'h1F1F);

      // Newest read wins, single reply
      cmd(1'b1, 7'h7C, 16'h0000, 1'b0);
      cmd(1'b1, 7'h26, 16'h0000, 1'b0);
      up_chk("newest wins", 1'b1, 20'h26000, 20'h000F0);
      up_chk("no 2nd reply", 1'b0, 20'h0, 20'h0);

      // Special-register write rules
      cmd(1'b0, 7'h26, 16'h1230, 1'b1);
      cmd(1'b1, 7'h26, 16'h0000, 1'b0);
      up_chk("power low nibble", 1'b1, 20'h26000, 20'h123F0);
      cmd(1'b0, 7'h7C, 16'h0000, 1'b1);
      cmd(1'b1, 7'h7C, 16'h0000, 1'b0);
      up_chk("vid1 read-only", 1'b1, 20'h7C000, 20'h4D4C0);
      cmd(1'b0, 7'h19, 16'hFFFF, 1'b1);
      cmd(1'b1, 7'h19, 16'h0000, 1'b0);
      up_chk("odd index", 1'b1, 20'h19000, 20'h00000);
      cmd(1'b0, 7'h18, 16'hAAAA, 1'b0);
      check("write no dv", {16'd0, pcm_vol}, 32'h1F1F);
      set_cmd(1'b1, 7'h18, 16'h0000, 1'b0);
      down_addr_valid = 1'b0;
      tick();
      clr_cmd();
      up_chk("addr tag low", 1'b0, 20'h0, 20'h0);

      // Reset-register write restores defaults
      cmd(1'b0, 7'h02, 16'h0000, 1'b1);
      check("master cleared", {16'd0, master_vol}, 32'h0000);
      cmd(1'b0, 7'h00, 16'h5555, 1'b1);
      cmd(1'b1, 7'h02, 16'h0000, 1'b0);
      up_chk("master default", 1'b1, 20'h02000, 20'h80000);
      check("master_vol def", {16'd0, master_vol}, 32'h8000);
      check("pcm_vol def", {16'd0, pcm_vol}, 32'h8808);
      cmd(1'b1, 7'h00, 16'h0000, 1'b0);
      up_chk("reg0 zero", 1'b1, 20'h00000, 20'h00000);

      // Same-cycle down and up strobes
      cmd(1'b1, 7'h7E, 16'h0000, 1'b0);
      set_cmd(1'b1, 7'h02, 16'h0000, 1'b0);
      up_chk("same-cycle old", 1'b1, 20'h7E000, 20'h4D530);
      up_chk("same-cycle new", 1'b1, 20'h02000, 20'h80000);
      cmd(1'b1, 7'h18, 16'h0000, 1'b0);
      set_cmd(1'b0, 7'h18, 16'h7777, 1'b1);
      up_chk("write not visible", 1'b1, 20'h18000, 20'h88080);
      cmd(1'b1, 7'h18, 16'h0000, 1'b0);
      up_chk("write visible", 1'b1, 20'h18000, 20'h77770);

      // Reset discards a pending read
      cmd(1'b1, 7'h18, 16'h0000, 1'b0);
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      idle_frames(20);
      up_chk("reset drop", 1'b0, 20'h0, 20'h0);
      check("pcm after rst", {16'd0, pcm_vol}, 32'h8808);
      check("ready after rst", {31'd0, up_frame_valid}, 32'd1);

      idle_frames(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
